// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if: one-channel-per-beat rate readout stream
interface spike_rate_decoder_if;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] out_ch;
    logic [7:0] out_rate;
    logic       out_last;
    modport master (output out_valid, out_ch, out_rate, out_last, input out_ready);
    modport slave  (input out_valid, out_ch, out_rate, out_last, output out_ready);
endinterface

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: windowed per-channel spike counting with double-buffered snapshot drain
module spike_rate_decoder (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  i_spike_in,
    input  logic                        i_spike_valid,
    input  logic [7:0]                  i_window,
    spike_rate_decoder_if.master        o_beat,
    output logic                        o_overrun
);
    typedef enum logic {IDLE, DRAIN} state_t;
    state_t      r_state, w_next;
    logic [7:0]  r_acc [8];
    logic [7:0]  r_snap [8];
    logic [7:0]  w_sum [8];
    logic [8:0]  r_samp, r_win, w_win;
    logic [2:0]  r_idx;
    logic        r_overrun;
    logic        w_drain, w_hs, w_fin, w_wend, w_load;
    always_comb begin
        for (int i = 0; i < 8; i++)
            w_sum[i] = (&r_acc[i]) ? r_acc[i] : r_acc[i] + {7'd0, i_spike_in[i]};
    end
    assign w_win   = {i_window == 8'd0, i_window};
    assign w_wend  = i_spike_valid && (r_samp == r_win - 9'd1);
    assign w_drain = r_state == DRAIN;
    assign w_hs    = w_drain && o_beat.out_ready;
    assign w_fin   = w_hs && (r_idx == 3'd7);
    // a window closing on the final handshake is not a collision
    assign w_load  = w_wend && (!w_drain || w_fin);
    assign o_overrun = r_overrun;
    always_comb begin
        w_next           = w_load ? DRAIN : (w_fin ? IDLE : r_state);
        o_beat.out_valid = w_drain;
        o_beat.out_ch    = r_idx;
        o_beat.out_rate  = r_snap[r_idx];
        o_beat.out_last  = w_drain && (&r_idx);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= 3'd0;
            r_samp    <= 9'd0;
            r_win     <= w_win;
            r_overrun <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                r_acc[i]  <= 8'd0;
                r_snap[i] <= 8'd0;
            end
        end else begin
            r_state <= w_next;
            if (w_load)
                r_idx <= 3'd0;
            else if (w_hs)
                r_idx <= r_idx + 3'd1;
            if (w_wend && !w_load)
                r_overrun <= 1'b1;
            if (i_spike_valid) begin
                r_samp <= w_wend ? 9'd0 : r_samp + 9'd1;
                for (int i = 0; i < 8; i++)
                    r_acc[i] <= w_wend ? 8'd0 : w_sum[i];
            end
            if (w_wend)
                r_win <= w_win;
            if (w_load)
                for (int i = 0; i < 8; i++)
                    r_snap[i] <= w_sum[i];
        end
    end
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: queue-of-beats reference model plus directed scenarios
module tb_spike_rate_decoder;
    logic       clk = 0, rst = 1, sv = 0, rdy = 0;
    logic [7:0] spk = 0, window = 8'd4;
    logic       ovr;
    int         total = 0, bad = 0;
    int         exp_r [8];
    spike_rate_decoder_if bus ();
    assign bus.out_ready = rdy;
    spike_rate_decoder dut (
        .clk(clk), .rst(rst), .i_spike_in(spk), .i_spike_valid(sv),
        .i_window(window), .o_beat(bus.master), .o_overrun(ovr)
    );
    always #5 clk = ~clk;

    task automatic chk(input string n, input int a, input int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d t=%0t", n, a, e, $time);
        end
    endtask

    // reference: pending beats of the snapshot being drained, head = next channel
    int  m_cnt [8];
    int  m_samp, m_win;
    bit  m_ovr, started = 0;
    int  q [$];
    always @(posedge clk) begin
        started <= 1;
        if (rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_samp = 0;
            m_win  = (window == 0) ? 256 : int'(window);
            q.delete();
            m_ovr  = 0;
        end else begin
            if (q.size() > 0 && rdy) void'(q.pop_front());
            if (sv) begin
                foreach (m_cnt[i]) m_cnt[i] = (m_cnt[i] + spk[i] > 255) ? 255 : m_cnt[i] + spk[i];
                m_samp++;
                if (m_samp == m_win) begin
                    if (q.size() == 0) foreach (m_cnt[i]) q.push_back(m_cnt[i]);
                    else m_ovr = 1;
                    foreach (m_cnt[i]) m_cnt[i] = 0;
                    m_samp = 0;
                    m_win  = (window == 0) ? 256 : int'(window);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("m_valid", bus.out_valid, q.size() != 0);
            chk("m_overrun", ovr, m_ovr);
            if (q.size() != 0) begin
                chk("m_ch", bus.out_ch, 8 - q.size());
                chk("m_rate", bus.out_rate, q[0]);
                chk("m_last", bus.out_last, q.size() == 1);
            end
        end
    end

    task automatic do_rst(input logic [7:0] w);
        @(negedge clk);
        rst = 1; window = w; sv = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic strobes(input int n, input logic [7:0] s);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            sv = 1; spk = s;
        end
    endtask

    // expects ready high and beat 0 on the current negedge
    task automatic drain_chk(input string n);
        for (int k = 0; k < 8; k++) begin
            chk({n, "_ch"}, bus.out_ch, k);
            chk({n, "_rate"}, bus.out_rate, exp_r[k]);
            chk({n, "_last"}, bus.out_last, k == 7);
            @(negedge clk);
        end
    endtask

    int  got [$];
    logic pv, pr;
    logic [2:0] pch;
    logic [7:0] prate;

    initial begin
        // reset state and basic count
        do_rst(8'd4);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_ch", bus.out_ch, 0);
        chk("rst_rate", bus.out_rate, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_ovr", ovr, 0);
        rdy = 1;
        strobes(4, 8'b0000_0101);
        @(negedge clk); sv = 0;
        chk("basic_lat", bus.out_valid, 1);
        exp_r = '{4, 0, 4, 0, 0, 0, 0, 0};
        drain_chk("basic");
        chk("basic_end", bus.out_valid, 0);

        // saturation with window 0 meaning 256
        do_rst(8'd0);
        strobes(256, 8'hFF);
        @(negedge clk); sv = 0;
        chk("sat_valid", bus.out_valid, 1);
        exp_r = '{255, 255, 255, 255, 255, 255, 255, 255};
        drain_chk("sat");

        // backpressure
        do_rst(8'd2);
        rdy = 0;
        strobes(1, 8'h81);
        strobes(1, 8'h80);
        pv = 0; pr = 0; pch = 0; prate = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            sv = 0;
            if (pv && !pr) begin
                chk("bp_hold_valid", bus.out_valid, 1);
                chk("bp_hold_ch", bus.out_ch, pch);
                chk("bp_hold_rate", bus.out_rate, prate);
            end
            rdy = (c % 2) == 1;
            if (bus.out_valid && rdy) got.push_back(bus.out_ch);
            pv = bus.out_valid; pr = rdy; pch = bus.out_ch; prate = bus.out_rate;
        end
        chk("bp_beats", got.size(), 8);
        foreach (got[k]) chk("bp_order", got[k], k);

        // overrun
        do_rst(8'd2);
        rdy = 0;
        strobes(2, 8'h03);
        strobes(8, 8'hF0);
        @(negedge clk); sv = 0; rdy = 1;
        chk("ovr_set", ovr, 1);
        exp_r = '{2, 2, 0, 0, 0, 0, 0, 0};
        drain_chk("ovr");
        chk("ovr_end", bus.out_valid, 0);
        chk("ovr_sticky", ovr, 1);

        // window end coincides with the ch7 handshake
        do_rst(8'd8);
        chk("ovr_clr", ovr, 0);
        rdy = 1;
        strobes(8, 8'h01);
        strobes(8, 8'h02);
        @(negedge clk); sv = 0;
        chk("coin_valid", bus.out_valid, 1);
        chk("coin_ovr", ovr, 0);
        exp_r = '{0, 8, 0, 0, 0, 0, 0, 0};
        drain_chk("coin");
        chk("coin_end", bus.out_valid, 0);

        // window change mid-window
        do_rst(8'd2);
        strobes(1, 8'h01);
        @(negedge clk); window = 8'd5; sv = 1; spk = 8'h01;
        @(negedge clk); sv = 0;
        chk("wc_first", bus.out_valid, 1);
        chk("wc_first_rate", bus.out_rate, 2);
        repeat (10) @(negedge clk);
        strobes(5, 8'h01);
        chk("wc_not_yet", bus.out_valid, 0);
        @(negedge clk); sv = 0;
        chk("wc_second", bus.out_valid, 1);
        chk("wc_second_rate", bus.out_rate, 5);
        for (int k = 0; k < 8 && bus.out_ch != 3'd3; k++) @(negedge clk);
        chk("rst_at_ch3", bus.out_ch, 3);
        rst = 1;
        @(negedge clk); rst = 0;
        chk("rst_mid_valid", bus.out_valid, 0);
        strobes(5, 8'h02);
        @(negedge clk); sv = 0;
        exp_r = '{0, 5, 0, 0, 0, 0, 0, 0};
        drain_chk("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Converts the 8-lane spike vector from the LIF neuron array back into per-channel spike counts over a programmable sampling window. Sits downstream of the neuron array and feeds the readout path through a valid/ready stream that emits one channel per beat. Accumulation is double-buffered: the next window is counted while the previous snapshot is drained.

## Interface
- N_CH, 8, number of spike lanes; fixed at 8 for this block.
- CNT_W, 8, width of each per-channel counter and of out_rate.
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- spike_in  input  8  spike vector; bit i is channel i.
- spike_valid  input  1  sample strobe; spike_in is counted only on cycles where this is high.
- window  input  8  samples per window; 0 means 256.
- out_valid  output  1  out_ch/out_rate/out_last hold a valid beat.
- out_ready  input  1  consumer accepts the beat when out_valid && out_ready.
- out_ch  output  3  channel index of the current beat.
- out_rate  output  8  spike count for out_ch over the window, saturated at 255.
- out_last  output  1  high on the channel N_CH-1 beat.
- overrun  output  1  sticky; a completed window was dropped because the drain was still busy.

## Operation
- Accumulator bank: 8 counters acc[i], 8-bit. On each spike_valid cycle, acc[i] <= acc[i] + spike_in[i], saturating at 255 (no wrap).
- Sample counter samp (9-bit) counts spike_valid cycles in the current window. win_reg (9-bit) holds the active window length; 0 on `window` maps to 256.
- Window end is the spike_valid cycle on which samp == win_reg-1:
  - This sample is included: snapshot snap[i] <= saturating acc[i] + spike_in[i].
  - acc[i] <= 0 and samp <= 0.
  - win_reg <= current `window`. Changes to `window` mid-window take effect only at the next boundary.
- Drain FSM, states IDLE and DRAIN:
  - IDLE -> DRAIN on window end. Set idx <= 0 and load snap.
  - DRAIN: out_valid=1, out_ch=idx, out_rate=snap[idx], out_last=(idx==7).
  - On handshake, idx <= idx+1. After the idx==7 handshake, go to IDLE.
  - Outputs stay stable while out_valid && !out_ready.
- Overrun: when a window ends while in DRAIN, the new snapshot is discarded. The in-progress drain is unaffected, overrun <= 1, and acc/samp are still cleared. overrun clears only on rst.
- A window end in the same cycle as the final (idx==7) handshake counts as not busy. The new snapshot is loaded, the FSM stays in DRAIN with idx <= 0, and no overrun is flagged.
- spike_in is ignored when spike_valid=0.

## Timing
- Reset values: out_valid=0, out_ch=0, out_rate=0, out_last=0, overrun=0. acc, snap, samp and idx are 0, state=IDLE, and win_reg <= `window` as sampled during reset.
- rst has priority over all activity. Asserting it mid-window or mid-drain discards the counts and any pending beats on the next edge.
- Latency: out_valid rises on the cycle after the window-end edge (registered output). Channel 0 is presented first.
- Throughput: with out_ready held high, one beat per cycle, so 8 cycles per drain. The minimum window that avoids overrun under continuous ready is 8 samples at one strobe per cycle.
- out_valid never drops without a handshake, except on rst.
- The first window after reset starts at the first spike_valid following reset release.

## Test plan
- Basic count: window=4, spike_in=8'b0000_0101 on 4 consecutive strobes, out_ready=1 -> 8 beats; ch0=4, ch2=4, all others 0. out_last only on ch7. out_valid rises the cycle after the 4th strobe.
- Saturation and zero-window: window=0 (256), spike_in=8'hFF for 256 strobes -> every out_rate=255, no wrap to 0.
- Backpressure: window=2, out_ready toggling 1/0 each cycle -> each beat held stable while ready=0. Exactly 8 beats in order 0..7, no duplicates or skips.
- Overrun: window=2, strobe every cycle, out_ready=0 for 10 cycles -> first snapshot is retained and drains correctly once ready=1. overrun=1 and stays high until rst.
- Boundary coincidence: arrange a window end on the same cycle as the ch7 handshake -> next cycle shows out_valid=1, out_ch=0 with the new counts, overrun stays 0.
- Mid-operation reset and window change: change `window` 2->5 mid-window, and separately assert rst during DRAIN at ch3.
  - Window change: the current window still closes after 2 samples; the next closes after 5.
  - Reset: out_valid=0 the cycle after rst, and the first post-reset drain reflects only post-reset spikes.
